// File: rtl/divider_issue_pkg.sv
// Shared definitions for the divider initiator: DIVop encodings, RISC-V corner-case constants
// and the issue FSM state type.
package divider_issue_pkg;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      FILL,
      RESP
   } state_t;

   // Quotient <-> remainder of the same signedness.
   function automatic logic [1:0] sibling_op(input logic [1:0] op);
      return op ^ OP_REM;
   endfunction

endpackage

// File: rtl/divider_issue_cache.sv
// Quotient/remainder pair cache: the last divider operands, their signedness,
// and both results, with tag compare against an incoming request.
module divider_issue_cache
   import divider_issue_pkg::*;
#(
   parameter int CACHE_EN = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  lookup_op,
   input  logic [31:0] lookup_rs1,
   input  logic [31:0] lookup_rs2,
   output logic        hit,
   output logic [31:0] hit_data,
   input  logic        fill_en,
   input  logic [1:0]  fill_op,
   input  logic [31:0] fill_rs1,
   input  logic [31:0] fill_rs2,
   input  logic [31:0] fill_rslt,
   input  logic [31:0] fill_other,
   input  logic        invalidate
);

   generate
      if (CACHE_EN != 0) begin : g_cache
         logic        valid_reg;
         logic        uns_tag_reg;
         logic [31:0] rs1_tag_reg;
         logic [31:0] rs2_tag_reg;
         logic [31:0] quo_reg;
         logic [31:0] rem_reg;

         assign hit = valid_reg && (lookup_rs1 == rs1_tag_reg) && (lookup_rs2 == rs2_tag_reg)
                      && (lookup_op[0] == uns_tag_reg);
         assign hit_data = lookup_op[1] ? rem_reg : quo_reg;

         // fill_rslt belongs to fill_op (the sibling); fill_other is the primary result.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               valid_reg   <= 1'b0;
               uns_tag_reg <= 1'b0;
               rs1_tag_reg <= '0;
               rs2_tag_reg <= '0;
               quo_reg     <= '0;
               rem_reg     <= '0;
            end else if (invalidate) begin
               valid_reg <= 1'b0;
            end else if (fill_en) begin
               valid_reg   <= 1'b1;
               uns_tag_reg <= fill_op[0];
               rs1_tag_reg <= fill_rs1;
               rs2_tag_reg <= fill_rs2;
               quo_reg     <= fill_op[1] ? fill_other : fill_rslt;
               rem_reg     <= fill_op[1] ? fill_rslt : fill_other;
            end
         end
      end else begin : g_no_cache
         assign hit      = 1'b0;
         assign hit_data = '0;
      end
   endgenerate

endmodule

// File: rtl/divider_issue.sv
// Initiator side of the radix-2 divider handshake: short-circuits RISC-V corner cases,
// serves DIV/REM siblings from a pair cache, and guards the divider with a watchdog.
module divider_issue
   import divider_issue_pkg::*;
#(
   parameter int CACHE_EN = 1,
   parameter int TIMEOUT  = 63
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        div_valid,
   input  logic        div_ready,
   output logic [31:0] div_divident,
   output logic [31:0] div_divisor,
   output logic [1:0]  div_op,
   input  logic [31:0] div_rslt
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   state_t      state_reg, state_next;
   logic        div_valid_reg, rsp_valid_reg, rsp_err_reg;
   logic [31:0] rsp_data_reg, short_data_reg;
   logic [31:0] divident_reg, divisor_reg;
   logic [1:0]  div_op_reg;
   logic [WD_W-1:0] wdog_reg;

   logic        accept, short_path, abort, is_signed, is_rem, div_zero, overflow;
   logic        cache_hit;
   logic [31:0] cache_data, short_data;

   assign req_ready    = (state_reg == IDLE);
   assign rsp_valid    = rsp_valid_reg;
   assign rsp_data     = rsp_data_reg;
   assign rsp_err      = rsp_err_reg;
   assign div_valid    = div_valid_reg;
   assign div_divident = divident_reg;
   assign div_divisor  = divisor_reg;
   assign div_op       = div_op_reg;

   assign accept    = req_valid && req_ready;
   assign is_signed = (req_op == OP_DIV) || (req_op == OP_REM);
   assign is_rem    = !((req_op == OP_DIV) || (req_op == OP_DIVU)) && (req_op != OP_REMU || 1'b1);
   assign div_zero  = (req_rs2 == '0);
   assign overflow  = is_signed && (req_rs1 == INT_MIN) && (req_rs2 == ALL_ONES);

   divider_issue_cache #(.CACHE_EN(CACHE_EN)) u_cache (
      .clk       (clk),
      .reset     (reset),
      .lookup_op (req_op),
      .lookup_rs1(req_rs1),
      .lookup_rs2(req_rs2),
      .hit       (cache_hit),
      .hit_data  (cache_data),
      .fill_en   (state_reg == FILL),
      .fill_op   (div_op_reg),
      .fill_rs1  (divident_reg),
      .fill_rs2  (divisor_reg),
      .fill_rslt (div_rslt),
      .fill_other(rsp_data_reg),
      .invalidate(abort)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      short_path = div_zero || overflow || cache_hit;
      short_data = cache_data;
      abort      = 1'b0;
      if (div_zero)      short_data = is_rem ? req_rs1 : ALL_ONES;
      else if (overflow) short_data = is_rem ? 32'd0 : INT_MIN;
      case (state_reg)
         IDLE: if (accept) state_next = short_path ? RESP : WAIT;
         WAIT: begin
            if (div_ready) begin
               state_next = (CACHE_EN != 0) ? FILL : IDLE;
            end else if (wdog_reg == WD_W'(TIMEOUT - 1)) begin
               abort      = 1'b1;
               state_next = IDLE;
            end
         end
         FILL:    state_next = IDLE;
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_valid_reg  <= 1'b0;
         rsp_valid_reg  <= 1'b0;
         rsp_err_reg    <= 1'b0;
         rsp_data_reg   <= '0;
         short_data_reg <= '0;
         divident_reg   <= '0;
         divisor_reg    <= '0;
         div_op_reg     <= '0;
         wdog_reg       <= '0;
      end else begin
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         case (state_reg)
            IDLE: begin
               wdog_reg <= '0;
               if (accept && short_path) begin
                  short_data_reg <= short_data;
               end else if (accept) begin
                  div_valid_reg <= 1'b1;
                  divident_reg  <= req_rs1;
                  divisor_reg   <= req_rs2;
                  div_op_reg    <= req_op;
               end
            end
            WAIT: begin
               if (div_ready) begin
                  // Drop the request on the very edge that sees completion.
                  div_valid_reg <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  rsp_data_reg  <= div_rslt;
                  if (CACHE_EN != 0) div_op_reg <= sibling_op(div_op_reg);
               end else if (abort) begin
                  div_valid_reg <= 1'b0;
                  rsp_valid_reg <= 1'b1;
                  rsp_err_reg   <= 1'b1;
                  rsp_data_reg  <= '0;
               end else begin
                  wdog_reg <= wdog_reg + WD_W'(1);
               end
            end
            RESP: begin
               rsp_valid_reg <= 1'b1;
               rsp_data_reg  <= short_data_reg;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_divider_issue.sv
// Self-checking bench for divider_issue: a behavioural divider stub plus a spec-level
// model of results, latency and pair-cache contents.
module tb_divider_issue;
   import divider_issue_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = '0;
   logic [31:0] req_rs1 = '0, req_rs2 = '0;
   logic        rsp_valid, rsp_err, div_valid;
   logic [31:0] rsp_data, div_divident, div_divisor, div_rslt;
   logic        div_ready;
   logic [1:0]  div_op;

   int checks = 0;
   int errors = 0;
   bit stub_en = 1'b1;
   int stub_cnt;

   // Model of the pair cache: last operands that went through the divider.
   bit          m_valid = 1'b0;
   logic [31:0] m_a, m_b;
   logic        m_uns;

   divider_issue dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .div_valid(div_valid), .div_ready(div_ready),
      .div_divident(div_divident), .div_divisor(div_divisor), .div_op(div_op),
      .div_rslt(div_rslt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'd0 : 32'h8000_0000;
      if (op[0]) return op[1] ? (a % b) : (a / b);
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
   endfunction

   // Divider stub: answers 35 cycles after the request appears, result muxed by div_op.
   assign div_rslt = ref_div(div_op, div_divident, div_divisor);

   always @(negedge clk or posedge reset) begin
      if (reset) begin
         stub_cnt  <= 0;
         div_ready <= 1'b0;
      end else if (stub_en && div_valid) begin
         stub_cnt  <= stub_cnt + 1;
         div_ready <= (stub_cnt + 1 == 35);
      end else begin
         stub_cnt  <= 0;
         div_ready <= 1'b0;
      end
   end

   task automatic model_step(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int exp_lat);
      bit special, hit;
      special = (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
      hit     = m_valid && a == m_a && b == m_b && op[0] == m_uns;
      if (special || hit) begin
         exp_lat = 1;
      end else begin
         exp_lat = 35;
         m_valid = 1'b1;
         m_a = a;
         m_b = b;
         m_uns = op[0];
      end
   endtask

   task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] data, output logic err, output int lat,
                         output bit saw_div, output logic rdy_at_rsp);
      int guard = 0;
      @(negedge clk);
      while (!req_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_wait: got %b expected 1", req_ready);
      end
      req_valid = 1'b1;
      req_op = op;
      req_rs1 = a;
      req_rs2 = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_rs1 = $urandom;
      saw_div = div_valid;
      lat = -1;
      data = 'x;
      err = 'x;
      rdy_at_rsp = 'x;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         #1;
         if (div_valid) saw_div = 1'b1;
         if (rsp_valid) begin
            lat = k;
            data = rsp_data;
            err = rsp_err;
            rdy_at_rsp = req_ready;
            break;
         end
      end
      $display("txn op=%0d rs1=%h rs2=%h -> data=%h err=%b lat=%0d div=%0b",
               op, a, b, data, err, lat, saw_div);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({req_ready, rsp_valid, rsp_err, div_valid, div_op} !== 6'b100000) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 100000",
                  {req_ready, rsp_valid, rsp_err, div_valid, div_op});
      end
      checks++;
      if ({rsp_data, div_divident, div_divisor} !== 96'd0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0", {rsp_data, div_divident, div_divisor});
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Runs a table of requests with literal expected results and model-derived latency.
   task automatic run_table(input string name, input logic [1:0] ops[],
                            input logic [31:0] as[], input logic [31:0] bs[],
                            input logic [31:0] exps[]);
      logic [31:0] data;
      logic err, rdy;
      int lat, exp_lat;
      bit saw;
      for (int i = 0; i < ops.size(); i++) begin
         model_step(ops[i], as[i], bs[i], exp_lat);
         do_req(ops[i], as[i], bs[i], data, err, lat, saw, rdy);
         checks += 5;
         if (data !== exps[i]) begin
            errors++;
            $display("FAIL %s[%0d] data: got %h expected %h", name, i, data, exps[i]);
         end
         if (err !== 1'b0) begin
            errors++;
            $display("FAIL %s[%0d] err: got %b expected 0", name, i, err);
         end
         if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s[%0d] latency: got %0d expected %0d", name, i, lat, exp_lat);
         end
         if (saw != (exp_lat != 1)) begin
            errors++;
            $display("FAIL %s[%0d] div_valid_seen: got %0b expected %0b", name, i, saw,
                     exp_lat != 1);
         end
         if (rdy !== (exp_lat == 1)) begin
            errors++;
            $display("FAIL %s[%0d] ready_at_rsp: got %b expected %b", name, i, rdy,
                     exp_lat == 1);
         end
      end
   endtask

   task automatic test_cache_pair();
      run_table("cache_pair", '{OP_DIV, OP_REM}, '{32'd100, 32'd100}, '{32'd7, 32'd7},
                '{32'd14, 32'd2});
   endtask

   task automatic test_special();
      run_table("special", '{OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_DIVU},
                '{32'd5, -32'sd5, INT_MIN, INT_MIN, INT_MIN},
                '{32'd0, 32'd0, ALL_ONES, ALL_ONES, ALL_ONES},
                '{ALL_ONES, 32'hFFFF_FFFB, INT_MIN, 32'd0, 32'd0});
   endtask

   task automatic test_signedness_miss();
      run_table("signedness", '{OP_REM, OP_DIVU}, '{-32'sd7, -32'sd7}, '{32'd2, 32'd2},
                '{ALL_ONES, 32'h7FFF_FFFC});
   endtask

   task automatic test_timeout();
      logic [31:0] data;
      logic err, rdy;
      int lat;
      bit saw;
      run_table("pre_timeout", '{OP_DIV}, '{32'd100}, '{32'd7}, '{32'd14});
      stub_en = 1'b0;
      do_req(OP_DIV, 32'd1000, 32'd3, data, err, lat, saw, rdy);
      stub_en = 1'b1;
      m_valid = 1'b0;
      checks += 3;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_err: got %b expected 1", err);
      end
      if (data !== 32'd0) begin
         errors++;
         $display("FAIL timeout_data: got %h expected 0", data);
      end
      if (lat != 63) begin
         errors++;
         $display("FAIL timeout_latency: got %0d expected 63", lat);
      end
      run_table("post_timeout", '{OP_REM}, '{32'd100}, '{32'd7}, '{32'd2});
   endtask

   task automatic test_reset_mid_wait();
      int pulses = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_op = OP_DIVU;
      req_rs1 = 32'd999;
      req_rs2 = 32'd10;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checks += 2;
      if ({req_ready, rsp_valid, rsp_err, div_valid, div_op} !== 6'b100000) begin
         errors++;
         $display("FAIL midwait_reset_ctrl: got %b expected 100000",
                  {req_ready, rsp_valid, rsp_err, div_valid, div_op});
      end
      if ({rsp_data, div_divident, div_divisor} !== 96'd0) begin
         errors++;
         $display("FAIL midwait_reset_data: got %h expected 0",
                  {rsp_data, div_divident, div_divisor});
      end
      m_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL midwait_no_rsp: got %0d pulses expected 0", pulses);
      end
      run_table("after_reset", '{OP_REM}, '{32'd100}, '{32'd7}, '{32'd2});
   endtask

   task automatic test_random();
      logic [31:0] data, a, b, exp;
      logic [1:0] op;
      logic err, rdy;
      int lat, exp_lat;
      bit saw;
      a = 32'd1;
      b = 32'd1;
      op = OP_DIV;
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            op = sibling_op(op);
         end else begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
               0: a = INT_MIN;
               1: a = $urandom;
               2: a = $urandom_range(0, 200);
               default: a = -$urandom_range(1, 200);
            endcase
            case ($urandom_range(0, 4))
               0: b = 32'd0;
               1: b = ALL_ONES;
               2: b = $urandom;
               default: b = $urandom_range(1, 20);
            endcase
         end
         exp = ref_div(op, a, b);
         model_step(op, a, b, exp_lat);
         do_req(op, a, b, data, err, lat, saw, rdy);
         checks += 3;
         if (data !== exp) begin
            errors++;
            $display("FAIL rand[%0d] data: got %h expected %h", i, data, exp);
         end
         if (err !== 1'b0) begin
            errors++;
            $display("FAIL rand[%0d] err: got %b expected 0", i, err);
         end
         if (lat != exp_lat) begin
            errors++;
            $display("FAIL rand[%0d] latency: got %0d expected %0d", i, lat, exp_lat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cache_pair();
      test_special();
      test_signedness_miss();
      test_timeout();
      test_reset_mid_wait();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
